// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline. It covers load-use
// bubbles, taken-branch flushes in ID and data-memory waits. Stall and flush
// outputs are combinational from the current state and inputs. A sticky
// timeout flag and a saturating stall-cycle counter are kept alongside.
module hazard_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15  // legal range 2..255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IFID_Rs,
  input  logic [4:0]  IFID_Rt,
  input  logic [4:0]  IDEX_Rt,
  input  logic        IDEX_MemRead,
  input  logic        ID_BranchTaken,
  input  logic        EXMEM_MemReq,
  input  logic        mem_ready,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        EXMEM_Hold,
  output logic        mem_timeout,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } state_t;

  // Last wait_cnt value before the wait is declared timed out.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q;
  logic [15:0] stall_count_q;

  logic lu_hit;
  logic mw_hit;
  logic pc_write_c, ifid_write_c, ifid_flush_c, idex_flush_c, exmem_hold_c;

  assign lu_hit = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                  ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
  assign mw_hit = EXMEM_MemReq && !mem_ready;

  // Next-state and combinational stall/flush decode.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pc_write_c   = 1'b1;
    ifid_write_c = 1'b1;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    exmem_hold_c = 1'b0;

    if (state_q == ERR) begin
      // Permanent freeze; only reset leaves this state.
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
      exmem_hold_c = 1'b1;
    end else if (state_q == MEM_WAIT && !mem_ready) begin
      // Still waiting on data memory.
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
      exmem_hold_c = 1'b1;
      wait_cnt_d   = wait_cnt_q + 8'd1;
      if (wait_cnt_q == WAIT_LAST) begin
        state_d = ERR;
      end
    end else if (mw_hit) begin
      // New memory wait seen from RUN or LU_STALL (false in a MEM_WAIT release).
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
      exmem_hold_c = 1'b1;
      wait_cnt_d   = 8'd0;
      state_d      = MEM_WAIT;
    end else if (lu_hit && state_q != LU_STALL) begin
      // One bubble; a concurrent taken branch stays held in ID.
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
      idex_flush_c = 1'b1;
      state_d      = LU_STALL;
    end else begin
      ifid_flush_c = ID_BranchTaken;
      state_d      = RUN;
    end
  end

  // Reset forces the outputs to the flush pattern immediately.
  always_comb begin
    if (!rst_n) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
      EXMEM_Hold = 1'b0;
    end else begin
      PC_Write   = pc_write_c;
      IFID_Write = ifid_write_c;
      IFID_Flush = ifid_flush_c;
      IDEX_Flush = idex_flush_c;
      EXMEM_Hold = exmem_hold_c;
    end
  end

  // State, wait counter, sticky timeout flag and saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_d == ERR) begin
        mem_timeout_q <= 1'b1;
      end
      if (!pc_write_c && state_q != ERR && stall_count_q != 16'hFFFF) begin
        stall_count_q <= stall_count_q + 16'd1;
      end
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl. Inputs change on the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  IFID_Rs, IFID_Rt, IDEX_Rt;
  logic        IDEX_MemRead, ID_BranchTaken, EXMEM_MemReq, mem_ready;
  logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Hold;
  logic        mem_timeout;
  logic [15:0] stall_count;
  logic [4:0]  ctl;

  int vectors     = 0;
  int miscompares = 0;

  // {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Hold}
  localparam logic [4:0] C_RUN    = 5'b11000;
  localparam logic [4:0] C_BRANCH = 5'b11100;
  localparam logic [4:0] C_BUBBLE = 5'b00010;
  localparam logic [4:0] C_FREEZE = 5'b00001;
  localparam logic [4:0] C_RESET  = 5'b00110;

  assign ctl = {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Hold};

  hazard_stall_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IFID_Rs        (IFID_Rs),
    .IFID_Rt        (IFID_Rt),
    .IDEX_Rt        (IDEX_Rt),
    .IDEX_MemRead   (IDEX_MemRead),
    .ID_BranchTaken (ID_BranchTaken),
    .EXMEM_MemReq   (EXMEM_MemReq),
    .mem_ready      (mem_ready),
    .PC_Write       (PC_Write),
    .IFID_Write     (IFID_Write),
    .IFID_Flush     (IFID_Flush),
    .IDEX_Flush     (IDEX_Flush),
    .EXMEM_Hold     (EXMEM_Hold),
    .mem_timeout    (mem_timeout),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    IFID_Rs = 5'd0; IFID_Rt = 5'd0; IDEX_Rt = 5'd0;
    IDEX_MemRead = 1'b0; ID_BranchTaken = 1'b0;
    EXMEM_MemReq = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    vectors++;
    if (ctl !== C_RESET) begin miscompares++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RESET); end
    vectors++;
    if (stall_count !== 16'd0 || mem_timeout !== 1'b0) begin
      miscompares++; $display("FAIL reset_regs got cnt=%0d to=%b exp cnt=0 to=0", stall_count, mem_timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (ctl !== C_RUN) begin miscompares++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl, C_RUN); end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    apply_reset();
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8; IFID_Rt = 5'd3;
    #1;
    vectors++;
    if (ctl !== C_BUBBLE) begin miscompares++; $display("FAIL lu_bubble got=%b exp=%b", ctl, C_BUBBLE); end
    @(negedge clk);
    #1;
    vectors++;
    if (ctl !== C_RUN) begin miscompares++; $display("FAIL lu_after got=%b exp=%b", ctl, C_RUN); end
    vectors++;
    if (stall_count !== 16'd1) begin miscompares++; $display("FAIL lu_count got=%0d exp=1", stall_count); end
    // Dependence through Rt instead of Rs.
    @(negedge clk);
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd9; IFID_Rs = 5'd1; IFID_Rt = 5'd9;
    #1;
    vectors++;
    if (ctl !== C_BUBBLE) begin miscompares++; $display("FAIL lu_rt_bubble got=%b exp=%b", ctl, C_BUBBLE); end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (ctl !== C_RUN) begin miscompares++; $display("FAIL lu_rt_after got=%b exp=%b", ctl, C_RUN); end
    $display("test_load_use done");
  endtask

  task automatic test_zero_reg();
    apply_reset();
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; IFID_Rs = 5'd0; IFID_Rt = 5'd0;
    #1;
    vectors++;
    if (ctl !== C_RUN) begin miscompares++; $display("FAIL zero_reg got=%b exp=%b", ctl, C_RUN); end
    @(negedge clk);
    IDEX_Rt = 5'd5; IFID_Rs = 5'd6; IFID_Rt = 5'd7;
    #1;
    vectors++;
    if (ctl !== C_RUN) begin miscompares++; $display("FAIL no_match got=%b exp=%b", ctl, C_RUN); end
    @(negedge clk);
    IDEX_MemRead = 1'b0; IDEX_Rt = 5'd6;
    #1;
    vectors++;
    if (ctl !== C_RUN) begin miscompares++; $display("FAIL not_load got=%b exp=%b", ctl, C_RUN); end
    vectors++;
    if (stall_count !== 16'd0) begin miscompares++; $display("FAIL zero_count got=%0d exp=0", stall_count); end
    $display("test_zero_reg done");
  endtask

  task automatic test_simultaneous();
    apply_reset();
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd4; IFID_Rs = 5'd4; ID_BranchTaken = 1'b1;
    #1;
    vectors++;
    if (ctl !== C_BUBBLE) begin miscompares++; $display("FAIL simul_bubble got=%b exp=%b", ctl, C_BUBBLE); end
    @(negedge clk);
    IDEX_MemRead = 1'b0;
    #1;
    vectors++;
    if (ctl !== C_BRANCH) begin miscompares++; $display("FAIL simul_branch got=%b exp=%b", ctl, C_BRANCH); end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (ctl !== C_RUN) begin miscompares++; $display("FAIL simul_after got=%b exp=%b", ctl, C_RUN); end
    vectors++;
    if (stall_count !== 16'd1) begin miscompares++; $display("FAIL simul_count got=%0d exp=1", stall_count); end
    $display("test_simultaneous done");
  endtask

  task automatic test_mem_wait();
    apply_reset();
    EXMEM_MemReq = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) ID_BranchTaken = 1'b1;
      #1;
      vectors++;
      if (ctl !== C_FREEZE) begin miscompares++; $display("FAIL mw_freeze[%0d] got=%b exp=%b", i, ctl, C_FREEZE); end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    vectors++;
    if (ctl !== C_BRANCH) begin miscompares++; $display("FAIL mw_release got=%b exp=%b", ctl, C_BRANCH); end
    vectors++;
    if (stall_count !== 16'd3) begin miscompares++; $display("FAIL mw_count got=%0d exp=3", stall_count); end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (ctl !== C_RUN || stall_count !== 16'd3) begin
      miscompares++; $display("FAIL mw_after got=%b/%0d exp=%b/3", ctl, stall_count, C_RUN);
    end
    $display("test_mem_wait done");
  endtask

  task automatic test_timeout();
    apply_reset();
    EXMEM_MemReq = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (ctl !== C_FREEZE || mem_timeout !== 1'b0) begin
        miscompares++; $display("FAIL to_wait[%0d] got=%b/%b exp=%b/0", i, ctl, mem_timeout, C_FREEZE);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (ctl !== C_FREEZE || mem_timeout !== 1'b1) begin
      miscompares++; $display("FAIL to_err got=%b/%b exp=%b/1", ctl, mem_timeout, C_FREEZE);
    end
    vectors++;
    if (stall_count !== 16'd5) begin miscompares++; $display("FAIL to_count got=%0d exp=5", stall_count); end
    @(negedge clk);
    mem_ready = 1'b1; EXMEM_MemReq = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (ctl !== C_FREEZE || mem_timeout !== 1'b1 || stall_count !== 16'd5) begin
        miscompares++;
        $display("FAIL to_sticky[%0d] got=%b/%b/%0d exp=%b/1/5", i, ctl, mem_timeout, stall_count, C_FREEZE);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ctl !== C_RESET || mem_timeout !== 1'b0 || stall_count !== 16'd0) begin
      miscompares++; $display("FAIL to_reset got=%b/%b/%0d exp=%b/0/0", ctl, mem_timeout, stall_count, C_RESET);
    end
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    EXMEM_MemReq = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    vectors++;
    if (ctl !== C_FREEZE || stall_count !== 16'd2) begin
      miscompares++; $display("FAIL mid_pre got=%b/%0d exp=%b/2", ctl, stall_count, C_FREEZE);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ctl !== C_RESET || stall_count !== 16'd0 || mem_timeout !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset got=%b/%0d/%b exp=%b/0/0", ctl, stall_count, mem_timeout, C_RESET);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (ctl !== C_RUN) begin miscompares++; $display("FAIL mid_after got=%b exp=%b", ctl, C_RUN); end
    $display("test_reset_mid_wait done");
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_simultaneous();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
